// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for a classic 5-stage pipeline.
// Detects load-use hazards, handles taken-branch flushes, instruction-fetch
// misses and data-memory wait states, and raises a sticky timeout when the
// data memory stays busy too long. Also counts PC-stall cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_id,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state
);

  // Wait counter just wide enough to hold WAIT_MAX.
  localparam int unsigned           WCNT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0]     WAIT_LIM = WCNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0]      CNT_SAT  = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2,
    ST_BAD      = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    stall_count_q, stall_count_d;

  // Decoded fields of the instruction sitting in IF/ID.
  logic [5:0] opcode;
  logic [4:0] rs_field;
  logic [4:0] rt_field;
  logic       rt_is_source;
  logic       lu;

  // The immediate/function bits never take part in hazard detection.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_id[15:0];

  assign opcode   = instr_id[31:26];
  assign rs_field = instr_id[25:21];
  assign rt_field = instr_id[20:16];

  // rt is only read as a source by R-type, beq, bne and sw.
  assign rt_is_source = (opcode == 6'h00) || (opcode == 6'h04) ||
                        (opcode == 6'h05) || (opcode == 6'h2B);

  // Load-use hazard: the load in ID/EX writes a register the ID instruction reads.
  // Register 0 is hard-wired, so a load into it never creates a dependency.
  assign lu = idex_memread && (idex_rt != 5'd0) &&
              ((idex_rt == rs_field) || ((idex_rt == rt_field) && rt_is_source));

  // Next-state and pipeline-control decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // a value unassigned; a missing default would infer a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;

    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (branch_taken) begin
          // Redirect fetch and squash the two wrong-path instructions.
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (dmem_busy) begin
          pipe_freeze = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = WCNT_W'(1);
        end else if (lu) begin
          // Hold PC and IF/ID one cycle, insert a bubble behind the load.
          idex_bubble = 1'b1;
        end else if (!imem_ready) begin
          // Fetch miss: keep PC, feed a NOP into IF/ID.
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        // Moore outputs: everything frozen; branches and hazards held in the
        // frozen stages are re-evaluated once back in RUN.
        pipe_freeze = 1'b1;
        if (!dmem_busy) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIM) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end

      ST_HALT: begin
        // Only reset leaves HALT.
        pipe_freeze = 1'b1;
        timeout_d   = 1'b1;
      end

      default: begin
        // Unreachable encoding: freeze and recover to RUN.
        pipe_freeze = 1'b1;
        state_d     = ST_RUN;
        wait_cnt_d  = '0;
      end
    endcase

    // While reset is held the pipeline is fed NOPs and bubbles.
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC is held (HALT excluded).
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_we && (state_q != ST_HALT) && (stall_count_q != CNT_SAT)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // State, wait counter, timeout flag and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      timeout_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // same pre-edge values, independent of statement order.
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_q     <= timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign state       = state_q;
  assign timeout_err = timeout_q;
  assign stall_count = stall_count_q;

endmodule
